ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetches 32-bit words and presents them to the decoder with redirect support.
// Define IFETCH_ICACHE_EN to build the direct-mapped I-cache; without it every fetch goes to memory.
module ifetch_unit #(
    parameter int unsigned ICACHE_IDX_W = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        need_inst,
    input  logic        clear_inst,
    input  logic [31:0] if_addr,
    output logic [31:0] PC,
    output logic [31:0] inst_in,
    output logic        instcache_ready_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);

    typedef enum logic [1:0] {FETCH, MISS, DISCARD, HOLD} state_e;

    state_e      state_q;
    logic [31:0] fetchPc_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        ready_q;
    logic        memReq_q;
    logic [31:0] memAddr_q;

    logic        cacheHit;
    logic [31:0] cacheData;
    logic        consume;
    logic [31:0] redirectPc_d;
    logic        unusedIfAddr;

    assign consume      = ready_q && !need_inst;
    assign redirectPc_d = {if_addr[31:1], 1'b0};
    assign unusedIfAddr = if_addr[0];

`ifdef IFETCH_ICACHE_EN
    localparam int unsigned LINES = 1 << ICACHE_IDX_W;
    localparam int unsigned TAG_W = 30 - ICACHE_IDX_W;

    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tagMem  [LINES];
    logic [31:0]             dataMem [LINES];
    logic [ICACHE_IDX_W-1:0] lookupIdx;
    logic [TAG_W-1:0]        lookupTag;
    logic                    fillEn;

    assign lookupIdx = fetchPc_q[ICACHE_IDX_W+1:2];
    assign lookupTag = fetchPc_q[31:ICACHE_IDX_W+2];
    assign cacheHit  = valid_q[lookupIdx] && (tagMem[lookupIdx] == lookupTag);
    assign cacheData = dataMem[lookupIdx];
    // A returning word fills its line even when a redirect arrives in the same cycle.
    assign fillEn    = rdy && (state_q == MISS) && mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fillEn) begin
            valid_q[lookupIdx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fillEn) begin
            tagMem[lookupIdx]  <= lookupTag;
            dataMem[lookupIdx] <= mem_data;
        end
    end
`else
    localparam int unsigned unusedIdxW = ICACHE_IDX_W;

    assign cacheHit  = 1'b0;
    assign cacheData = '0;
`endif

    // Redirect beats every state and consumption; an outstanding response is drained in DISCARD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            fetchPc_q <= RESET_PC;
            pc_q      <= '0;
            inst_q    <= '0;
            ready_q   <= 1'b0;
            memReq_q  <= 1'b0;
            memAddr_q <= '0;
        end else if (rdy) begin
            if (clear_inst) begin
                fetchPc_q <= redirectPc_d;
                ready_q   <= 1'b0;
                memReq_q  <= 1'b0;
                if ((state_q == MISS || state_q == DISCARD) && !mem_ready) begin
                    state_q <= DISCARD;
                end else begin
                    state_q <= FETCH;
                end
            end else begin
                case (state_q)
                    FETCH: begin
                        if (cacheHit) begin
                            pc_q    <= fetchPc_q;
                            inst_q  <= cacheData;
                            ready_q <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            memReq_q  <= 1'b1;
                            memAddr_q <= fetchPc_q;
                            state_q   <= MISS;
                        end
                    end
                    MISS: begin
                        if (mem_ready) begin
                            memReq_q <= 1'b0;
                            pc_q     <= fetchPc_q;
                            inst_q   <= mem_data;
                            ready_q  <= 1'b1;
                            state_q  <= HOLD;
                        end
                    end
                    DISCARD: begin
                        if (mem_ready) begin
                            state_q <= FETCH;
                        end
                    end
                    HOLD: begin
                        if (consume) begin
                            fetchPc_q <= pc_q + 32'd4;
                            ready_q   <= 1'b0;
                            state_q   <= FETCH;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign PC                  = pc_q;
    assign inst_in             = inst_q;
    assign instcache_ready_out = ready_q;
    assign mem_req             = memReq_q;
    assign mem_addr            = memAddr_q;

endmodule
